uno_deck_pool: RTL and testbench
================================

// Module: uno_deck_pool
// PURPOSE
//  Parametrised UNO card pool: draw pile plus discard pile in one block, with a seeded Fisher-Yates shuffle.
//  Serves multi-card draws (1..MAX_DRAW) and takes discarded cards back.
//  When the draw pile runs dry, it refills the draw pile from the discard pile and reshuffles with no host action.
//  Sits between the game-control FSM and the player-hand blocks.
// PARAMETERS
//  DECK_SIZE  108                 total cards in circulation; must be <= 2**IDX_W
//  CARD_W     6                   card code width, {colour[1:0], value[3:0]}
//  MAX_DRAW   4                   largest count accepted on i_draw_cnt
//  LFSR_W     8                   shuffle LFSR width; must be >= IDX_W; taps come from uno_deck_pkg
//  IDX_W      $clog2(DECK_SIZE)   derived, not overridable
// PORTS
//  i_clk           in   1                    clock
//  i_rst           in   1                    synchronous, active-high reset
//  i_start         in   1                    load canonical deck and shuffle; accepted only when o_ready
//  i_seed          in   LFSR_W               LFSR seed, sampled on accepted i_start
//  i_draw_req      in   1                    draw request; accepted when i_draw_req & o_ready
//  i_draw_cnt      in   $clog2(MAX_DRAW+1)   cards to draw, 1..MAX_DRAW; 0 or >MAX_DRAW treated as 1
//  i_discard_valid in   1                    discard card offered
//  i_discard_card  in   CARD_W               discarded card code
//  o_discard_ready out  1                    high in S_IDLE while discard count < DECK_SIZE
//  o_ready         out  1                    high in S_IDLE only
//  o_card_valid    out  1                    one drawn card per asserted cycle
//  o_card          out  CARD_W               drawn card; 0 when o_card_valid is low
//  o_draw_done     out  1                    1-cycle pulse, coincident with the last card, or alone on shortfall
//  o_short         out  1                    qualifies o_draw_done: fewer cards delivered than requested
//  o_draw_count    out  IDX_W+1              cards in draw pile
//  o_discard_count out  IDX_W+1              cards in discard pile
// BEHAVIOUR
//  Reset (next edge, any state):
//   - state S_IDLE; every output 0 except o_ready=1 and o_discard_ready=1; both counts 0; LFSR = 1.
//   - Reset mid-operation abandons the operation; pile contents are don't-care once counts are 0.
//  LFSR advances every cycle in every state. Seed 0 is replaced by 1.
//  FSM states: S_IDLE, S_FILL, S_SHUFFLE, S_DRAW, S_RECYCLE.
//  S_IDLE:
//   - i_start has priority over i_draw_req and discard. Accepted start -> S_FILL, discard count cleared.
//   - Otherwise an accepted draw -> S_DRAW with rem=i_draw_cnt.
//   - Otherwise an accepted discard writes discard[count] and increments the discard count.
//   - i_start and i_draw_req are ignored outside S_IDLE. Discards are only accepted in S_IDLE.
//  S_FILL: draw[i] = deck_card(i), one card per cycle, i = 0..DECK_SIZE-1 (DECK_SIZE cycles). Then S_SHUFFLE with end = count-1.
//  S_SHUFFLE, one attempt per cycle:
//   - r = lfsr[IDX_W-1:0].
//   - If r > end: retry (rejection sampling).
//   - Else swap draw[r] and draw[end], then end--.
//   - When end==0 (or count<=1): go to S_IDLE, or back to S_DRAW if entered from S_RECYCLE.
//  S_DRAW, per cycle:
//   - If draw count > 0: o_card = draw[count-1], o_card_valid=1, count--, rem--.
//   - When rem reaches 0: o_draw_done=1, go to S_IDLE.
//   - If draw count==0 and discard count > KEEP: go to S_RECYCLE.
//   - If draw count==0 and discard count <= KEEP: o_draw_done=1, o_short=1, no card, go to S_IDLE.
//  Latency: draw accepted at cycle T -> cards at T+1..T+k with no refill; done on T+k.
//  S_RECYCLE:
//   - Copy discard[j] -> draw[j], one per cycle, for j < discard count - KEEP.
//   - Then shuffle the refilled pile, then resume S_DRAW with the remaining rem.
//  KEEP = 1 with DECK_KEEP_TOP_DISCARD_EN defined, 0 without.
//  Counts never exceed DECK_SIZE. Draw-pile and discard-pile indices never wrap.
// CONFIGURATION
//  DECK_KEEP_TOP_DISCARD_EN defined:
//   - Recycle leaves the most recent discard (the face-up card) behind.
//   - That card moves to discard[0]; discard count becomes 1 after recycle.
//  DECK_KEEP_TOP_DISCARD_EN undefined:
//   - The whole discard pile is recycled; discard count becomes 0.
// STRUCTURE
//  uno_deck_pkg holds:
//   - card_t and the colour enum (RED=0, YELLOW=1, GREEN=2, BLUE=3).
//   - Value codes: 0-9, SKIP=10, REV=11, DRAW2=12, WILD=13, WILD4=14.
//   - Function deck_card(idx): 27 cards per colour = 0 x1; 1-9, SKIP, REV, DRAW2 x2 each; WILD x1; WILD4 x1.
//   - Tap table lfsr_taps(width) for widths 7..10.
//  Sub-module deck_lfsr: Fibonacci LFSR with params WIDTH and TAPS; ports i_clk, i_rst, i_load, i_seed, o_value.
// TESTING
//  1. Reset, then i_start with seed 8'h5A -> o_ready low DECK_SIZE+ cycles. Returns with draw count 108, discard count 0.
//     Card histogram matches deck_card exactly; order differs from canonical.
//  2. Same seed twice -> identical draw sequence. Seed 8'h00 behaves exactly like seed 8'h01.
//  3. Draw 4 from a full deck -> valid on T+1..T+4, done on T+4 with o_short=0, draw count 104.
//  4. Draw count 2, discard 5 cards, then draw 4 -> 2 cards, recycle, 2 more cards, done.
//     Final discard count is 1 with DECK_KEEP_TOP_DISCARD_EN, 0 without.
//  5. Both piles empty, draw 3 -> no valid cards, then o_draw_done=1 and o_short=1.
//  6. Assert i_rst in the middle of S_SHUFFLE -> next cycle: S_IDLE, counts 0, all outputs at reset values.
//     Also: i_start and i_draw_req asserted together -> only start is taken.

Source files
------------

// File: rtl/uno_deck_pkg.sv
// Shared types, card codes, canonical deck order and LFSR tap table for the UNO card pool.
package uno_deck_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    BLUE   = 2'd3
  } colour_e;

  typedef struct packed {
    colour_e    colour;
    logic [3:0] value;
  } card_t;

  localparam logic [3:0] VAL_SKIP  = 4'd10;
  localparam logic [3:0] VAL_REV   = 4'd11;
  localparam logic [3:0] VAL_DRAW2 = 4'd12;
  localparam logic [3:0] VAL_WILD  = 4'd13;
  localparam logic [3:0] VAL_WILD4 = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_DRAW,
    S_RECYCLE
  } state_e;

  // 27 cards per colour: one 0, two each of 1..12 (1-9, SKIP, REV, DRAW2), one WILD, one WILD4
  function automatic card_t deck_card(input int idx);
    card_t c;
    int    k;
    k        = idx % 27;
    c.colour = colour_e'(2'((idx / 27) % 4));
    if (k == 0)       c.value = 4'd0;
    else if (k <= 24) c.value = 4'((k + 1) / 2);
    else if (k == 25) c.value = VAL_WILD;
    else              c.value = VAL_WILD4;
    return c;
  endfunction

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Fibonacci LFSR used as the shuffle random source; seed 0 is forced to 1 so it never locks up.
module deck_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(uno_deck_pkg::lfsr_taps(WIDTH))
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_value
);

  logic fb;
  assign fb = ^(o_value & TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst)       o_value <= WIDTH'(1);
    else if (i_load) o_value <= (i_seed == '0) ? WIDTH'(1) : i_seed;
    else             o_value <= {o_value[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/uno_deck_pool.sv
// UNO draw/discard pool with seeded shuffle and automatic refill from the discard pile.
// Build option DECK_KEEP_TOP_DISCARD_EN: refill leaves the face-up discard behind.
module uno_deck_pool
  import uno_deck_pkg::*;
#(
  parameter int DECK_SIZE = 108,
  parameter int CARD_W    = 6,
  parameter int MAX_DRAW  = 4,
  parameter int LFSR_W    = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [LFSR_W-1:0]            i_seed,
  input  logic                         i_draw_req,
  input  logic [$clog2(MAX_DRAW+1)-1:0] i_draw_cnt,
  input  logic                         i_discard_valid,
  input  logic [CARD_W-1:0]            i_discard_card,
  output logic                         o_discard_ready,
  output logic                         o_ready,
  output logic                         o_card_valid,
  output logic [CARD_W-1:0]            o_card,
  output logic                         o_draw_done,
  output logic                         o_short,
  output logic [$clog2(DECK_SIZE):0]   o_draw_count,
  output logic [$clog2(DECK_SIZE):0]   o_discard_count
);

  localparam int IDX_W = $clog2(DECK_SIZE);
  localparam int CNT_W = $clog2(MAX_DRAW + 1);
`ifdef DECK_KEEP_TOP_DISCARD_EN
  localparam int KEEP = 1;
`else
  localparam int KEEP = 0;
`endif
  localparam logic [IDX_W:0]   DECK_CNT = (IDX_W + 1)'(DECK_SIZE);
  localparam logic [IDX_W:0]   KEEP_CNT = (IDX_W + 1)'(KEEP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

  logic [CARD_W-1:0] draw_pile    [DECK_SIZE];
  logic [CARD_W-1:0] discard_pile [DECK_SIZE];

  state_e            state, state_next;
  logic [IDX_W:0]    draw_cnt_q, disc_cnt_q;
  logic [IDX_W-1:0]  idx_q, end_q;
  logic [CNT_W-1:0]  rem_q, cnt_sane;
  logic              resume_q;
  logic [LFSR_W-1:0] lfsr_value;
  logic [IDX_W-1:0]  rnd, top_idx, disc_top, recycle_last;
  logic [IDX_W:0]    recycle_n;
  logic              start_acc, draw_acc, disc_acc, swap_en;
  card_t             fill_card;
  logic              unused_lfsr_hi;

  assign rnd            = lfsr_value[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr_value[LFSR_W-1:IDX_W];
  assign top_idx        = IDX_W'(draw_cnt_q - 1'b1);
  assign disc_top       = IDX_W'(disc_cnt_q - 1'b1);
  assign recycle_n      = disc_cnt_q - KEEP_CNT;
  assign recycle_last   = IDX_W'(recycle_n - 1'b1);
  assign fill_card      = deck_card(int'(idx_q));
  assign cnt_sane       = (i_draw_cnt == '0 || i_draw_cnt > CNT_W'(MAX_DRAW)) ? CNT_W'(1) : i_draw_cnt;

  assign o_ready         = (state == S_IDLE);
  assign o_discard_ready = o_ready && (disc_cnt_q < DECK_CNT);
  assign o_draw_count    = draw_cnt_q;
  assign o_discard_count = disc_cnt_q;

  deck_lfsr #(.WIDTH(LFSR_W)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (start_acc),
    .i_seed (i_seed),
    .o_value(lfsr_value)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    o_card_valid = 1'b0;
    o_card       = '0;
    o_draw_done  = 1'b0;
    o_short      = 1'b0;
    start_acc    = 1'b0;
    draw_acc     = 1'b0;
    disc_acc     = 1'b0;
    swap_en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          start_acc  = 1'b1;
          state_next = S_FILL;
        end else if (i_draw_req) begin
          draw_acc   = 1'b1;
          state_next = S_DRAW;
        end else if (i_discard_valid && o_discard_ready) begin
          disc_acc = 1'b1;
        end
      end
      S_FILL: if (idx_q == LAST_IDX) state_next = S_SHUFFLE;
      S_SHUFFLE: begin
        if (end_q == '0) state_next = resume_q ? S_DRAW : S_IDLE;
        else if (rnd <= end_q) swap_en = 1'b1;
      end
      S_DRAW: begin
        if (draw_cnt_q != '0) begin
          o_card_valid = 1'b1;
          o_card       = draw_pile[top_idx];
          if (rem_q == CNT_W'(1)) begin
            o_draw_done = 1'b1;
            state_next  = S_IDLE;
          end
        end else if (disc_cnt_q > KEEP_CNT) begin
          state_next = S_RECYCLE;
        end else begin
          o_draw_done = 1'b1;
          o_short     = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_RECYCLE: if (idx_q == recycle_last) state_next = S_SHUFFLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      draw_cnt_q <= '0;
      disc_cnt_q <= '0;
      idx_q      <= '0;
      end_q      <= '0;
      rem_q      <= '0;
      resume_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_acc) begin
            draw_cnt_q <= '0;
            disc_cnt_q <= '0;
            idx_q      <= '0;
            resume_q   <= 1'b0;
          end else if (draw_acc) begin
            rem_q <= cnt_sane;
          end else if (disc_acc) begin
            discard_pile[disc_cnt_q[IDX_W-1:0]] <= i_discard_card;
            disc_cnt_q <= disc_cnt_q + 1'b1;
          end
        end
        S_FILL: begin
          draw_pile[idx_q] <= CARD_W'(fill_card);
          idx_q            <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            draw_cnt_q <= DECK_CNT;
            end_q      <= LAST_IDX;
          end
        end
        S_SHUFFLE: begin
          if (end_q == '0) begin
            resume_q <= 1'b0;
          end else if (swap_en) begin
            draw_pile[rnd]   <= draw_pile[end_q];
            draw_pile[end_q] <= draw_pile[rnd];
            end_q            <= end_q - 1'b1;
          end
        end
        S_DRAW: begin
          if (draw_cnt_q != '0) begin
            draw_cnt_q <= draw_cnt_q - 1'b1;
            rem_q      <= rem_q - 1'b1;
          end else if (state_next == S_RECYCLE) begin
            idx_q    <= '0;
            resume_q <= 1'b1;
          end
        end
        S_RECYCLE: begin
          draw_pile[idx_q] <= discard_pile[idx_q];
          idx_q            <= idx_q + 1'b1;
          if (idx_q == recycle_last) begin
            draw_cnt_q <= recycle_n;
            end_q      <= recycle_last;
            disc_cnt_q <= KEEP_CNT;
            // face-up card drops to the bottom of the now-empty discard pile
            if (KEEP != 0) discard_pile[0] <= discard_pile[disc_top];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uno_deck_pool.sv
// Directed self-checking bench for uno_deck_pool: shuffle, draws, refill, shortfall and reset.
module tb_uno_deck_pool;

  localparam int DECK_SIZE = 108;
`ifdef DECK_KEEP_TOP_DISCARD_EN
  localparam int KEEP = 1;
`else
  localparam int KEEP = 0;
`endif
  localparam int BUSY_MAX = 30000;

  logic       clk = 1'b0;
  logic       rst, start, draw_req, discard_valid;
  logic [7:0] seed;
  logic [2:0] draw_cnt;
  logic [5:0] discard_card;
  logic       discard_ready, ready, card_valid, draw_done, short_f;
  logic [5:0] card;
  logic [7:0] draw_count, discard_count;

  uno_deck_pool dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_seed         (seed),
    .i_draw_req     (draw_req),
    .i_draw_cnt     (draw_cnt),
    .i_discard_valid(discard_valid),
    .i_discard_card (discard_card),
    .o_discard_ready(discard_ready),
    .o_ready        (ready),
    .o_card_valid   (card_valid),
    .o_card         (card),
    .o_draw_done    (draw_done),
    .o_short        (short_f),
    .o_draw_count   (draw_count),
    .o_discard_count(discard_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] seq_cur [DECK_SIZE];
  logic [5:0] seq_ref [DECK_SIZE];
  logic [5:0] canon   [DECK_SIZE];
  logic [5:0] disc_cards [5];
  int         seq_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ready"}, ready, 1);
    check_val({tag, "_discard_ready"}, discard_ready, 1);
    check_val({tag, "_card_valid"}, card_valid, 0);
    check_val({tag, "_card"}, card, 0);
    check_val({tag, "_done"}, draw_done, 0);
    check_val({tag, "_short"}, short_f, 0);
    check_val({tag, "_draw_count"}, draw_count, 0);
    check_val({tag, "_discard_count"}, discard_count, 0);
  endtask

  task automatic do_start(input logic [7:0] s, output int busy);
    @(negedge clk); start = 1'b1; seed = s;
    @(negedge clk); start = 1'b0;
    busy = 0;
    while (!ready && busy < BUSY_MAX) begin
      busy++;
      @(negedge clk);
    end
    check_val("start_returns_ready", ready, 1);
  endtask

  // exp_done_cyc <= 0 skips the latency check (refill cases)
  task automatic do_draw(input int n, input int exp_cards, input bit exp_short, input int exp_done_cyc);
    int k, got_cards;
    bit seen_done, got_short;
    @(negedge clk); draw_req = 1'b1; draw_cnt = 3'(n);
    @(negedge clk); draw_req = 1'b0; draw_cnt = 3'd0;
    k = 0; got_cards = 0; seen_done = 0; got_short = 0;
    while (!seen_done && k < BUSY_MAX) begin
      k++;
      if (card_valid) begin
        if (seq_n < DECK_SIZE) seq_cur[seq_n] = card;
        seq_n++;
        got_cards++;
      end
      if (draw_done) begin
        seen_done = 1;
        got_short = short_f;
      end else begin
        @(negedge clk);
      end
    end
    check_val("draw_done_seen", seen_done, 1);
    check_val("draw_cards", got_cards, exp_cards);
    check_val("draw_short", got_short, exp_short);
    if (exp_done_cyc > 0) check_val("draw_done_cycle", k, exp_done_cyc);
    @(negedge clk);
  endtask

  task automatic do_discard(input logic [5:0] c);
    @(negedge clk);
    check_val("discard_ready", discard_ready, 1);
    discard_valid = 1'b1; discard_card = c;
    @(negedge clk); discard_valid = 1'b0;
  endtask

  task automatic run_deck(input logic [7:0] s);
    int busy;
    do_start(s, busy);
    check_val("busy_at_least_deck", busy >= DECK_SIZE, 1);
    check_val("full_draw_count", draw_count, DECK_SIZE);
    check_val("full_discard_count", discard_count, 0);
    seq_n = 0;
    for (int i = 0; i < DECK_SIZE / 4; i++) begin
      do_draw(4, 4, 0, 4);
      if (i == 0) check_val("count_after_first_draw", draw_count, DECK_SIZE - 4);
    end
    check_val("exhausted_draw_count", draw_count, 0);
  endtask

  function automatic int seq_diff();
    int d = 0;
    for (int i = 0; i < DECK_SIZE; i++) if (seq_cur[i] !== seq_ref[i]) d++;
    return d;
  endfunction

  function automatic bit in_recycled(input logic [5:0] c, input int n);
    bit hit = 0;
    for (int i = 0; i < n; i++) if (disc_cards[i] == c) hit = 1;
    return hit;
  endfunction

  initial begin
    int hist [64];
    int busy, p, dfwd, drev;
    bit seen_valid;

    disc_cards = '{6'h01, 6'h12, 6'h23, 6'h35, 6'h0E};
    p = 0;
    for (int col = 0; col < 4; col++) begin
      canon[p] = 6'(col * 16); p++;
      for (int v = 1; v <= 12; v++) begin
        canon[p] = 6'(col * 16 + v); p++;
        canon[p] = 6'(col * 16 + v); p++;
      end
      canon[p] = 6'(col * 16 + 13); p++;
      canon[p] = 6'(col * 16 + 14); p++;
    end

    rst = 1'b1; start = 1'b0; seed = 8'h00; draw_req = 1'b0; draw_cnt = 3'd0;
    discard_valid = 1'b0; discard_card = 6'h00; seq_n = 0;
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // both piles empty: immediate shortfall
    do_draw(3, 0, 1, 1);

    // seeded shuffle: full deck, histogram and order
    run_deck(8'h5A);
    for (int c = 0; c < 64; c++) hist[c] = 0;
    for (int i = 0; i < DECK_SIZE; i++) hist[seq_cur[i]]++;
    for (int c = 0; c < 64; c++)
      check_val($sformatf("hist_%02h", c), hist[c],
                ((c % 16) == 0 || (c % 16) == 13 || (c % 16) == 14) ? 1 :
                ((c % 16) <= 12) ? 2 : 0);
    dfwd = 0; drev = 0;
    for (int i = 0; i < DECK_SIZE; i++) begin
      if (seq_cur[i] != canon[i]) dfwd++;
      if (seq_cur[i] != canon[DECK_SIZE - 1 - i]) drev++;
    end
    check_val("order_shuffled", (dfwd > 0) && (drev > 0), 1);
    for (int i = 0; i < DECK_SIZE; i++) seq_ref[i] = seq_cur[i];
    do_draw(2, 0, 1, 1);

    // determinism and seed 0 == seed 1
    run_deck(8'h5A);
    check_val("same_seed_same_order", seq_diff(), 0);
    run_deck(8'h00);
    for (int i = 0; i < DECK_SIZE; i++) seq_ref[i] = seq_cur[i];
    run_deck(8'h01);
    check_val("seed0_equals_seed1", seq_diff(), 0);

    // refill from discard pile mid-draw, plus out-of-range draw counts
    do_start(8'h5A, busy);
    seq_n = 0;
    for (int i = 0; i < 26; i++) do_draw(4, 4, 0, 4);
    do_draw(0, 1, 0, 1);
    do_draw(7, 1, 0, 1);
    check_val("pre_recycle_draw_count", draw_count, 2);
    for (int i = 0; i < 5; i++) do_discard(disc_cards[i]);
    check_val("discards_counted", discard_count, 5);
    seq_n = 0;
    do_draw(4, 4, 0, -1);
    check_val("post_recycle_draw_count", draw_count, 5 - KEEP - 2);
    check_val("post_recycle_discard_count", discard_count, KEEP);
    check_val("recycled_card_a", in_recycled(seq_cur[2], 5 - KEEP), 1);
    check_val("recycled_card_b", in_recycled(seq_cur[3], 5 - KEEP), 1);

    // start and draw together: only start is taken
    @(negedge clk); start = 1'b1; draw_req = 1'b1; draw_cnt = 3'd4; seed = 8'h33;
    @(negedge clk); start = 1'b0; draw_req = 1'b0; draw_cnt = 3'd0;
    busy = 0; seen_valid = 0;
    while (!ready && busy < BUSY_MAX) begin
      if (card_valid) seen_valid = 1;
      busy++;
      @(negedge clk);
    end
    check_val("start_wins_ready", ready, 1);
    check_val("start_wins_no_cards", seen_valid, 0);
    check_val("start_wins_draw_count", draw_count, DECK_SIZE);
    check_val("start_wins_discard_count", discard_count, 0);

    // reset in the middle of the shuffle
    @(negedge clk); start = 1'b1; seed = 8'hC3;
    @(negedge clk); start = 1'b0;
    repeat (119) @(negedge clk);
    check_val("busy_before_reset", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_shuffle_reset");
    rst = 1'b0;
    do_draw(1, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
